// File: rtl/gf233_pkg.sv
// Shared definitions for the GF(2^233) arithmetic blocks.
//   FIELD_M_DEF / TRI_K_DEF : default field degree and middle trinomial exponent
//   HALF_LO / HALF_HI       : Karatsuba split widths (low half, high half)
//   state_t                 : sequential multiplier FSM states
//   fe_t                    : one field element, bit i = coefficient of x^i
package gf233_pkg;

    localparam int FIELD_M_DEF = 233;
    localparam int TRI_K_DEF   = 74;
    localparam int HALF_LO     = 117;
    localparam int HALF_HI     = 116;
    localparam int PROD_W      = 2*FIELD_M_DEF - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_L = 3'd1,
        MUL_H = 3'd2,
        MUL_M = 3'd3,
        RED   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    typedef logic [FIELD_M_DEF-1:0] fe_t;

endpackage

// File: rtl/gf233_ks_seq_mul_if.sv
// Operand/result handshake bundle for gf233_ks_seq_mul.
//   master : point-arithmetic sequencer side (drives operands, accepts result)
//   slave  : multiplier side
//   in_valid/in_ready : operand handshake, a/b operands
//   out_valid/out_ready : result handshake, d result
//   busy : multiplier is not idle
interface gf233_ks_seq_mul_if;
    import gf233_pkg::*;

    logic in_valid;
    logic in_ready;
    fe_t  a;
    fe_t  b;
    logic out_valid;
    logic out_ready;
    fe_t  d;
    logic busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, d, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, d, busy
    );
endinterface

// File: rtl/gf233_reduce.sv
// Reduction of a 465-bit carry-less product modulo x^233 + x^TRI_K + 1.
//   c : unreduced product, bit i = coefficient of x^i
//   r : reduced field element
// Two folds are enough while TRI_K <= 115: after the first fold the
// overflow above x^232 is below x^(232+TRI_K), and folding that once more
// lands entirely under x^233.
module gf233_reduce
    import gf233_pkg::*;
#(
    parameter int TRI_K = TRI_K_DEF
) (
    input  logic [PROD_W-1:0] c,
    output fe_t               r
);
    localparam int M = FIELD_M_DEF;

    logic [PROD_W-1:0] t1;
    fe_t               h2;

    // x^233 == x^TRI_K + 1, so each high coefficient lands at i and i+TRI_K.
    assign t1 = {{(M-1){1'b0}}, c[M-1:0]}
              ^ {{M{1'b0}}, c[PROD_W-1:M]}
              ^ ({{M{1'b0}}, c[PROD_W-1:M]} << TRI_K);

    assign h2 = {1'b0, t1[PROD_W-1:M]};
    assign r  = t1[M-1:0] ^ h2 ^ (h2 << TRI_K);
endmodule

// File: rtl/ks117.sv
// Carry-less 117 x 117 polynomial multiplier, purely combinational.
//   a, b : 117-bit operands
//   p    : 233-bit carry-less product
module ks117 (
    input  logic [116:0] a,
    input  logic [116:0] b,
    output logic [232:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < 117; i++) begin
            if (b[i]) begin
                p = p ^ ({116'b0, a} << i);
            end
        end
    end
endmodule

// File: rtl/gf233_ks_seq_mul.sv
// Sequential GF(2^233) multiplier with one time-shared 117-bit Karatsuba leg.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of gf233_ks_seq_mul_if (a/b in, d out, valid/ready
//                on both sides, busy)
// Result is accepted four edges after the operand handshake and held until
// the consumer takes it; no new operands are accepted meanwhile.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   MUL_L | low halves multiplied -> pl
//   MUL_H | high halves multiplied -> ph
//   MUL_M | half sums multiplied -> pm
//   RED   | Karatsuba recombine + reduce -> d
//   HOLD  | d valid, waiting for out_ready
module gf233_ks_seq_mul
    import gf233_pkg::*;
#(
    parameter int FIELD_M = FIELD_M_DEF,
    parameter int TRI_K   = TRI_K_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    gf233_ks_seq_mul_if.slave   bus
);
    if (FIELD_M != 233) begin : g_bad_field
        $error("gf233_ks_seq_mul: only FIELD_M = 233 is supported");
    end
    if (TRI_K < 1 || TRI_K > 115) begin : g_bad_tri
        $error("gf233_ks_seq_mul: TRI_K must be in 1..115");
    end

    state_t state_q, state_d;

    fe_t  a_r, b_r;
    fe_t  pl, ph, pm;
    fe_t  d_r;
    logic out_valid_r;

    logic [HALF_LO-1:0] ks_a, ks_b;
    fe_t                ks_p;
    fe_t                mid;
    logic [PROD_W-1:0]  c;
    fe_t                red_out;

    ks117 u_ks117 (
        .a (ks_a),
        .b (ks_b),
        .p (ks_p)
    );

    // pl + x^117*(pl+ph+pm) + x^234*ph; ph fits in 231 bits so nothing is lost.
    assign mid = pl ^ ph ^ pm;
    assign c   = {{(FIELD_M_DEF-1){1'b0}}, pl}
               ^ ({{(FIELD_M_DEF-1){1'b0}}, mid} << HALF_LO)
               ^ ({{(FIELD_M_DEF-1){1'b0}}, ph} << (2*HALF_LO));

    gf233_reduce #(.TRI_K(TRI_K)) u_reduce (
        .c (c),
        .r (red_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ks_a    = '0;
        ks_b    = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) state_d = MUL_L;
            end
            MUL_L: begin
                ks_a    = a_r[HALF_LO-1:0];
                ks_b    = b_r[HALF_LO-1:0];
                state_d = MUL_H;
            end
            MUL_H: begin
                ks_a    = {1'b0, a_r[FIELD_M_DEF-1:HALF_LO]};
                ks_b    = {1'b0, b_r[FIELD_M_DEF-1:HALF_LO]};
                state_d = MUL_M;
            end
            MUL_M: begin
                ks_a    = a_r[HALF_LO-1:0] ^ {1'b0, a_r[FIELD_M_DEF-1:HALF_LO]};
                ks_b    = b_r[HALF_LO-1:0] ^ {1'b0, b_r[FIELD_M_DEF-1:HALF_LO]};
                state_d = RED;
            end
            RED: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (out_valid_r && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            pl          <= '0;
            ph          <= '0;
            pm          <= '0;
            d_r         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                    end
                end
                MUL_L: pl <= ks_p;
                MUL_H: ph <= ks_p;
                MUL_M: pm <= ks_p;
                RED: begin
                    d_r         <= red_out;
                    out_valid_r <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.d         = d_r;
endmodule

// File: tb/tb_gf233_ks_seq_mul.sv
// Directed and randomised bench for gf233_ks_seq_mul. Inputs change on the
// falling edge, outputs are sampled 1 time unit after the rising edge.
module tb_gf233_ks_seq_mul;
    import gf233_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    gf233_ks_seq_mul_if bus ();

    gf233_ks_seq_mul #(.FIELD_M(233), .TRI_K(74)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input fe_t got, input fe_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic fe_t gf_mul_ref(input fe_t x, input fe_t y);
        fe_t  r;
        fe_t  poly;
        logic msb;
        r       = '0;
        poly    = '0;
        poly[74] = 1'b1;
        poly[0]  = 1'b1;
        for (int i = 232; i >= 0; i--) begin
            msb = r[232];
            r   = r << 1;
            if (msb) r = r ^ poly;
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    function automatic fe_t rnd_fe();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w[232:0];
    endfunction

    // Present operands, wait for acceptance, then wait for out_valid.
    // Leaves the DUT in HOLD; lat = edges from accept to out_valid.
    task automatic run_op(input fe_t av, input fe_t bv, input string tag,
                          input bit junk, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_in_ready"}, fe_t'(bus.in_ready), fe_t'(1));
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (junk) begin
            bus.a        = rnd_fe();
            bus.b        = rnd_fe();
            bus.in_valid = 1'b1;
        end
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            bus.in_valid = 1'b0;
            if (junk) begin
                bus.a = rnd_fe();
                bus.b = rnd_fe();
            end
        end
        chk({tag, "_out_valid"}, fe_t'(bus.out_valid), fe_t'(1));
    endtask

    // Complete the output handshake and confirm IDLE one edge later.
    task automatic finish_op(input fe_t exp, input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, {bus.in_ready, bus.out_valid, bus.busy}, fe_t'(3'b100));
        chk({tag, "_d_kept"}, bus.d, exp);
    endtask

    initial begin
        fe_t av, bv, ev, d0;
        int  lat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #12;
        chk("rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, fe_t'(3'b100));
        chk("rst_d", bus.d, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 1 * x = x, latency 4
        av = '0; av[0] = 1'b1;
        bv = '0; bv[1] = 1'b1;
        run_op(av, bv, "t1", 1'b0, lat);
        chk("t1_lat", fe_t'(lat), fe_t'(4));
        chk("t1_d", bus.d, bv);
        finish_op(bv, "t1");

        // 2: x^232 * x = x^74 + 1
        av = '0; av[232] = 1'b1;
        bv = '0; bv[1] = 1'b1;
        ev = '0; ev[74] = 1'b1; ev[0] = 1'b1;
        run_op(av, bv, "t2", 1'b0, lat);
        chk("t2_d", bus.d, ev);
        finish_op(ev, "t2");

        // 3: x^464 = x^231 + x^146 + x^72
        av = '0; av[232] = 1'b1;
        ev = '0; ev[231] = 1'b1; ev[146] = 1'b1; ev[72] = 1'b1;
        run_op(av, av, "t3", 1'b0, lat);
        chk("t3_d", bus.d, ev);
        finish_op(ev, "t3");

        // 4: all-ones * 1 with 10 cycles of backpressure
        av = '1;
        bv = '0; bv[0] = 1'b1;
        run_op(av, bv, "t4", 1'b1, lat);
        chk("t4_d", bus.d, av);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_d", bus.d, av);
            chk("t4_hold_flags", {bus.in_ready, bus.out_valid, bus.busy}, fe_t'(3'b011));
        end
        finish_op(av, "t4");

        // 5: reset during MUL_H, then 3 * 3 = 5
        @(negedge clk);
        bus.a = rnd_fe();
        bus.b = rnd_fe();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_in_mul_h", fe_t'(bus.busy), fe_t'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_abort_flags", {bus.in_ready, bus.out_valid, bus.busy}, fe_t'(3'b100));
        chk("t5_abort_d", bus.d, '0);
        @(negedge clk);
        rst_n = 1'b1;
        av = fe_t'(3);
        ev = fe_t'(5);
        run_op(av, av, "t5", 1'b0, lat);
        chk("t5_lat", fe_t'(lat), fe_t'(4));
        chk("t5_d", bus.d, ev);
        finish_op(ev, "t5");

        // 6: random operands against the bit-serial model
        for (int n = 0; n < 3000; n++) begin
            av = rnd_fe();
            bv = rnd_fe();
            if (n % 7 == 0) av = gf_mul_ref(av, bv) ^ av;
            ev = gf_mul_ref(av, bv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(av, bv, "rnd", ($urandom_range(0, 1) == 1), lat);
            d0 = bus.d;
            chk("rnd_d", d0, ev);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_op(ev, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "global timeout");
    end
endmodule
